// File: rtl/seg_display.sv
// seg_display: four-digit multiplexed seven-segment driver for an MM:SS clock.
// Scans one digit per REFRESH_DIV cycles and latches a fresh snapshot of all
// four BCD inputs once per frame, so a frame never mixes old and new digits.
// A selected digit can be blinked with a BLINK_DIV-cycle half period.
// Optional feature: define SEG_LZ_BLANK_EN to blank a leading zero in min_1.
// All outputs are active-low and registered.
module seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_1_val,
  input  logic [3:0] min_0_val,
  input  logic [3:0] sec_1_val,
  input  logic [3:0] sec_0_val,
  input  logic       blink_en,
  input  logic [1:0] blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       idx;
  logic             tick;

  logic [3:0] snap_min_1;
  logic [3:0] snap_min_0;
  logic [3:0] snap_sec_1;
  logic [3:0] snap_sec_0;

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  logic [3:0] digit_val;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing.
  function automatic logic [6:0] decode_bcd(input logic [3:0] v);
    case (v)
      4'd0:    decode_bcd = 7'b1000000;
      4'd1:    decode_bcd = 7'b1111001;
      4'd2:    decode_bcd = 7'b0100100;
      4'd3:    decode_bcd = 7'b0110000;
      4'd4:    decode_bcd = 7'b0011001;
      4'd5:    decode_bcd = 7'b0010010;
      4'd6:    decode_bcd = 7'b0000010;
      4'd7:    decode_bcd = 7'b1111000;
      4'd8:    decode_bcd = 7'b0000000;
      4'd9:    decode_bcd = 7'b0010000;
      default: decode_bcd = 7'b1111111;
    endcase
  endfunction

  assign tick = (ref_cnt == REF_MAX);

  // Refresh divider and digit index: one slot per REFRESH_DIV cycles.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Frame snapshot: all four digits are captured together at the end of slot 3.
  // NOTE: the snapshot is reset because its contents are visible right after
  // reset (digit 0 must read as 0), unlike a scratch store that is written first.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_min_1 <= 4'd0;
      snap_min_0 <= 4'd0;
      snap_sec_1 <= 4'd0;
      snap_sec_0 <= 4'd0;
    end else if (tick && idx == 2'd3) begin
      snap_min_1 <= min_1_val;
      snap_min_0 <= min_0_val;
      snap_sec_1 <= sec_1_val;
      snap_sec_0 <= sec_0_val;
    end
  end

  // Blink timer: held clear while blinking is off so each blink starts visible.
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Next output pattern from the current slot, snapshot and blink state.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    digit_val = snap_sec_0;
    case (idx)
      2'd0: digit_val = snap_sec_0;
      2'd1: digit_val = snap_sec_1;
      2'd2: digit_val = snap_min_0;
      2'd3: digit_val = snap_min_1;
      default: digit_val = snap_sec_0;
    endcase

    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = decode_bcd(digit_val);
    dp_nxt  = (idx == 2'd2) ? 1'b0 : 1'b1;

    if (blink_en && blink_phase && idx == blink_sel) begin
      an_nxt = 4'b1111;
    end

`ifdef SEG_LZ_BLANK_EN
    if (idx == 2'd3 && snap_min_1 == 4'd0) begin
      seg_nxt = 7'b1111111;
      dp_nxt  = 1'b1;
    end
`endif
  end

  // Output registers: one cycle behind idx, all dark while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: self-checking bench for seg_display with REFRESH_DIV=4 and
// BLINK_DIV=8, so a slot is 4 cycles and a frame is 16 cycles. Expected
// outputs are queued when stimulus is applied and popped as each cycle's
// outputs are sampled on the falling edge.
module tb_seg_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 8;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] MIN1_ZERO_SEG = 7'b1111111;
`else
  localparam logic [6:0] MIN1_ZERO_SEG = 7'b1000000;
`endif

  // Anode pattern and dp level per slot, index 0 = rightmost digit.
  localparam logic [3:0][3:0] AN_TBL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]      DP_TBL = 4'b1011;

  typedef struct {
    logic [3:0]      min_1;
    logic [3:0]      min_0;
    logic [3:0]      sec_1;
    logic [3:0]      sec_0;
    logic [3:0][6:0] seg;    // {slot3, slot2, slot1, slot0}
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         an_only;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] min_1_val;
  logic [3:0] min_0_val;
  logic [3:0] sec_1_val;
  logic [3:0] sec_0_val;
  logic       blink_en;
  logic [1:0] blink_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  exp_t sb[$];
  vec_t vecs[4];

  seg_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .min_1_val(min_1_val),
    .min_0_val(min_0_val),
    .sec_1_val(sec_1_val),
    .sec_0_val(sec_0_val),
    .blink_en (blink_en),
    .blink_sel(blink_sel),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an/seg/dp=%b_%b_%b, want %b_%b_%b", name,
               act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Advance to the falling edge that follows rising edge number 'target'.
  task automatic to_edge(input int target);
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic push(input string name, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input bit an_only);
    exp_t e;
    e.name = name; e.an = a; e.seg = s; e.dp = d; e.an_only = an_only;
    sb.push_back(e);
  endtask

  task automatic push_slot(input string name, input int k, input logic [6:0] s, input int n);
    for (int j = 0; j < n; j++) push(name, AN_TBL[k], s, DP_TBL[k], 1'b0);
  endtask

  task automatic push_frame(input string name, input logic [3:0][6:0] segs);
    for (int k = 0; k < 4; k++) push_slot(name, k, segs[k], 4);
  endtask

  // Sample n consecutive cycles starting after edge first_edge.
  task automatic run_check(input int first_edge, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      to_edge(first_edge + j);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at edge %0d", pos);
      end else begin
        e = sb.pop_front();
        if (e.an_only)
          check($sformatf("%s@%0d", e.name, pos), {an, 8'h00}, {e.an, 8'h00});
        else
          check($sformatf("%s@%0d", e.name, pos), {an, seg, dp}, {e.an, e.seg, e.dp});
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd5, 4'd9, 4'd3, 4'd7,
                {7'b0010010, 7'b0010000, 7'b0110000, 7'b1111000}};
    vecs[1] = '{4'd0, 4'd1, 4'd4, 4'd6,
                {MIN1_ZERO_SEG, 7'b1111001, 7'b0011001, 7'b0000010}};
    vecs[2] = '{4'd8, 4'hF, 4'hC, 4'd2,
                {7'b0000000, 7'b1111111, 7'b1111111, 7'b0100100}};
    vecs[3] = '{4'd7, 4'd6, 4'd5, 4'hA,
                {7'b1111000, 7'b0000010, 7'b0010010, 7'b1111111}};

    rst = 1'b1;
    min_1_val = 4'd0; min_0_val = 4'd0; sec_1_val = 4'd0; sec_0_val = 4'd0;
    blink_en = 1'b0; blink_sel = 2'd0;

    // Held in reset for three cycles: everything dark.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_%0d", i), {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    end
    rst = 1'b0;
    pos = 0;

    // Frame 0 shows the all-zero snapshot, starting with digit 0 right after release.
    push_frame("frame0", {MIN1_ZERO_SEG, 7'b1000000, 7'b1000000, 7'b1000000});
    run_check(1, 15);
    void'(sb.pop_back());

    // Digit patterns: inputs change in the very cycle of the frame-end capture.
    for (int i = 0; i < 4; i++) begin
      to_edge(32 * i + 15);
      min_1_val = vecs[i].min_1; min_0_val = vecs[i].min_0;
      sec_1_val = vecs[i].sec_1; sec_0_val = vecs[i].sec_0;
      push_frame($sformatf("vec%0d", i), vecs[i].seg);
      run_check(32 * i + 17, 16);
    end

    // Snapshot isolation: a mid-frame change only shows up in the next frame.
    to_edge(143);
    min_1_val = 4'd5; min_0_val = 4'd9; sec_1_val = 4'd3; sec_0_val = 4'd7;
    push_frame("snap_old", {7'b0010010, 7'b0010000, 7'b0110000, 7'b1111000});
    run_check(145, 5);
    sec_0_val = 4'd1;
    min_1_val = 4'd2;
    push_frame("snap_new", {7'b0100100, 7'b0010000, 7'b0110000, 7'b1111001});
    run_check(150, 11);
    run_check(161, 16);

    // Blink digit 2: visible 8 cycles, dark 8, visible again; then a short
    // disable must restart the blink in its visible phase.
    begin
      logic [3:0][6:0] bseg;
      int p;
      bseg = {7'b0100100, 7'b0010000, 7'b0110000, 7'b1111001};
      p = 16 * 11 + 2;
      to_edge(p);
      blink_en  = 1'b1;
      blink_sel = 2'd2;
      for (int e = 1; e <= 40; e++) begin
        int  k;
        bit  dark;
        k    = ((p + e - 1) % 16) / 4;
        dark = (e <= 28) && (((e - 1) / 8) % 2 == 1) && (k == 2);
        if (dark) push("blink_dark", 4'b1111, 7'b0000000, 1'b0, 1'b1);
        else      push("blink_vis", AN_TBL[k], bseg[k], DP_TBL[k], 1'b0);
        run_check(p + e, 1);
        if (e == 28) blink_en = 1'b0;
        if (e == 32) blink_en = 1'b1;
      end
    end

    // Reset in mid-frame and mid-blink: everything restarts from zero.
    blink_sel = 2'd0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("midreset_%0d", i), {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    end
    rst = 1'b0;
    pos = 0;
    push_slot("post_reset", 0, 7'b1000000, 4);
    push_slot("post_reset", 1, 7'b1000000, 1);
    run_check(1, 5);
    push_slot("post_reset_f1", 0, 7'b1111001, 4);
    run_check(17, 4);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries unconsumed", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot (4 slots at 100 MHz give 500 Hz per digit); legal range >=2.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink phase (2 Hz blink at 100 MHz); legal range >=2.
REQ-003 SHALL have port clk, input, 1, board clock (100 MHz); the block uses only this one clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports min_1_val, min_0_val, sec_1_val and sec_0_val, each input, 4 bits, BCD digit values from the digit counters.
REQ-006 SHALL have port blink_en, input, 1, which enables blinking of the selected digit.
REQ-007 SHALL have port blink_sel, input, 2, selecting the blinking digit: 0=sec_0, 1=sec_1, 2=min_0, 3=min_1.
REQ-008 SHALL have port an, output, 4, active-low anodes; an[i] drives digit i (0 = rightmost, sec_0).
REQ-009 SHALL have port seg, output, 7, active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-011 SHALL run ref_cnt from 0 to REFRESH_DIV-1 and wrap; a tick occurs in the cycle where ref_cnt==REFRESH_DIV-1.
REQ-012 SHALL advance the digit index idx (2 bits) by one on each tick, wrapping from 3 to 0.
REQ-013 SHALL capture all four value inputs into snapshot registers on a tick while idx==3, so the displayed frame never mixes old and new digits.
REQ-014 SHALL register an, seg and dp every cycle from the current idx, snapshot and blink state, giving 1 cycle of latency from an idx change to the outputs.
REQ-015 SHALL drive an to ~(4'b0001<<idx), except as REQ-018 states.
REQ-016 SHALL decode digit values 0-9 to the standard pattern (for example 0=1000000, 1=1111001, 3=0110000, 5=0010010, 7=1111000, 9=0010000) and values 10-15 to 1111111 with the anode still asserted.
REQ-017 SHALL drive dp=0 when idx==2 (colon between minutes and seconds) and dp=1 otherwise.
REQ-018 SHALL hold blink_cnt and blink_phase at 0 while blink_en=0; while blink_en=1, blink_cnt SHALL count 0..BLINK_DIV-1 and blink_phase SHALL toggle on each wrap; when blink_en=1, blink_phase=1 and idx==blink_sel, an SHALL be 4'b1111.
REQ-019 SHALL start each blink in the visible phase (phase 0) for the first BLINK_DIV cycles after blink_en rises.
REQ-020 SHALL apply a change to blink_sel or blink_en at the next output register update, with no effect on ref_cnt, idx or the snapshot.
REQ-021 SHALL, when a tick with idx==3 and a value change on the inputs occur in the same cycle, capture the input values present in that cycle.

Reset
REQ-022 SHALL, while rst=1, set ref_cnt=0, idx=0, all snapshots=0, blink_cnt=0, blink_phase=0, an=4'b1111, seg=7'b1111111 and dp=1.
REQ-023 SHALL drive an=1110 and seg=1000000 in the first cycle after rst deasserts.
REQ-024 SHALL restart all counters from 0 on an assertion of rst mid-frame or mid-blink, with no partial state kept.

Configuration
REQ-025 SHALL, when macro SEG_LZ_BLANK_EN is defined, blank the min_1 digit (seg=1111111, dp=1, anode still asserted) when its snapshot value is 0.
REQ-026 SHALL, when SEG_LZ_BLANK_EN is undefined, show min_1 value 0 as 1000000.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-027 Reset: rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1; cycle after release -> an=1110, seg=1000000.
REQ-028 Scan: min_1=5, min_0=9, sec_1=3, sec_0=7, after first snapshot -> an sequence 1110/1101/1011/0111 with seg 1111000/0110000/0010000/0010010, each held for 4 cycles; dp=0 only while an=1011.
REQ-029 Snapshot: change sec_0 from 7 to 1 while idx==1 -> seg at an=1110 stays 1111000 until the frame after the next idx 3->0 wrap, then becomes 1111001.
REQ-030 Blink: blink_en=1, blink_sel=2 -> an=1011 appears in the first 8 cycles, is replaced by 1111 in the next 8 and reappears after that; digits 0, 1 and 3 are unaffected.
REQ-031 Invalid: sec_1=4'hC -> an=1101 with seg=1111111.
REQ-032 Macro: min_1=0 -> at an=0111, seg=1111111 with SEG_LZ_BLANK_EN defined and seg=1000000 without it.
